// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder.
//   state_t      : responder FSM states
//   WORD_BYTES   : bytes per RAM word
//   MAX_MEM_LAT  : largest supported backing RAM read latency
//   word_addr()  : byte address -> word address (callers truncate to ADDR_W)
package cpu_mem_pkg;

    typedef enum logic [2:0] {IDLE, DRD, DWR, IRD, RESP} state_t;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned MAX_MEM_LAT = 4;

    function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
        return 32'(byte_addr >> $clog2(WORD_BYTES));
    endfunction

endpackage

// File: rtl/cpu_mem_ibuf.sv
// One-entry instruction buffer for the CPU memory responder.
// Holds the last fetched word address, its data and a valid bit.
//   clk, rst            : clock, asynchronous active-low reset
//   lookup_addr         : word address to compare against the buffer
//   hit, hit_data       : combinational hit indication and buffered word
//   fill_en/addr/data   : load a freshly fetched word
//   inv_en/addr         : write to RAM; drops the entry if it matches
module cpu_mem_ibuf import cpu_mem_pkg::*; #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_W-1:0]         lookup_addr,
    output logic                      hit,
    output logic [8*WORD_BYTES-1:0]   hit_data,
    input  logic                      fill_en,
    input  logic [ADDR_W-1:0]         fill_addr,
    input  logic [8*WORD_BYTES-1:0]   fill_data,
    input  logic                      inv_en,
    input  logic [ADDR_W-1:0]         inv_addr
);

    logic                    buf_valid;
    logic [ADDR_W-1:0]       buf_addr;
    logic [8*WORD_BYTES-1:0] buf_data;

    assign hit      = buf_valid && (buf_addr == lookup_addr);
    assign hit_data = buf_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
        end else begin
            if (fill_en) begin
                buf_valid <= 1'b1;
                buf_addr  <= fill_addr;
                buf_data  <= fill_data;
            end else if (inv_en && (inv_addr == buf_addr)) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the CPU instruction/data request link.
// Arbitrates the instruction port and the data port onto one single-ported
// synchronous RAM (data first), returns read data with valid pulses,
// acknowledges writes and drives per-port stalls.
//   clk, rst                               : clock, async active-low reset
//   instr_addr, rd_instr_en                : instruction fetch request
//   instr, instr_valid, instr_stall        : fetch result / pulse / stall
//   data_addr, rd_data_en, wr_data_en,
//   wrt_data                               : data access request
//   data, data_valid, data_stall           : data result / pulse / stall
//   err                                    : sticky protocol error
//   mem_addr, mem_re, mem_we, mem_wdata,
//   mem_rdata                              : backing RAM interface
// Optional: define CPU_MEM_RESPONDER_IBUF_EN to add a one-entry
// instruction buffer that answers repeated fetches without the RAM.
module cpu_mem_responder import cpu_mem_pkg::*; #(
    parameter int unsigned ADDR_W  = 14,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instr_addr,
    input  logic              rd_instr_en,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              instr_stall,
    input  logic [31:0]       data_addr,
    input  logic              rd_data_en,
    input  logic              wr_data_en,
    input  logic [31:0]       wrt_data,
    output logic [31:0]       data,
    output logic              data_valid,
    output logic              data_stall,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_MEM_LAT);

    state_t             state, state_nx, grant;
    logic [CNT_W-1:0]   lat_cnt, lat_cnt_nx;
    logic [ADDR_W-1:0]  addr_q;
    logic               resp_instr;
    logic               err_set;
    logic               ibuf_hit;
    logic [31:0]        ibuf_data;
    logic [ADDR_W-1:0]  i_word, d_word;
    logic               rd_done;

    assign i_word  = ADDR_W'(word_addr(instr_addr));
    assign d_word  = ADDR_W'(word_addr(data_addr));
    assign rd_done = (state == DRD || state == IRD) && (lat_cnt == '0);

`ifdef CPU_MEM_RESPONDER_IBUF_EN
    cpu_mem_ibuf #(.ADDR_W(ADDR_W)) u_ibuf (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (i_word),
        .hit         (ibuf_hit),
        .hit_data    (ibuf_data),
        .fill_en     (rd_done && state == IRD),
        .fill_addr   (addr_q),
        .fill_data   (mem_rdata),
        .inv_en      (mem_we),
        .inv_addr    (mem_addr)
    );
`else
    assign ibuf_hit  = 1'b0;
    assign ibuf_data = '0;
`endif

    // The RAM strobes are issued combinationally in the accepting IDLE cycle,
    // so a write completes there (DWR never occupies the state register) and
    // read data arrives MEM_LAT cycles later. Gating with rst keeps every
    // output low while reset is asserted even if requests are held.
    always_comb begin
        state_nx   = state;
        lat_cnt_nx = lat_cnt;
        grant      = IDLE;
        err_set    = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = addr_q;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (rst) begin
                    if (wr_data_en)       grant = DWR;
                    else if (rd_data_en)  grant = DRD;
                    else if (rd_instr_en) grant = IRD;
                end
                case (grant)
                    DWR: begin
                        mem_we    = 1'b1;
                        mem_addr  = d_word;
                        mem_wdata = wrt_data;
                        state_nx  = RESP;
                        err_set   = rd_data_en || (data_addr[1:0] != 2'b00);
                    end
                    DRD: begin
                        mem_re     = 1'b1;
                        mem_addr   = d_word;
                        state_nx   = DRD;
                        lat_cnt_nx = CNT_W'(MEM_LAT - 1);
                        err_set    = (data_addr[1:0] != 2'b00);
                    end
                    IRD: begin
                        mem_addr = i_word;
                        err_set  = (instr_addr[1:0] != 2'b00);
                        if (ibuf_hit) begin
                            state_nx = RESP;
                        end else begin
                            mem_re     = 1'b1;
                            state_nx   = IRD;
                            lat_cnt_nx = CNT_W'(MEM_LAT - 1);
                        end
                    end
                    default: ;
                endcase
            end
            DRD, IRD: begin
                if (lat_cnt == '0) state_nx = RESP;
                else               lat_cnt_nx = lat_cnt - 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            addr_q     <= '0;
            resp_instr <= 1'b0;
            instr      <= '0;
            data       <= '0;
            err        <= 1'b0;
        end else begin
            state   <= state_nx;
            lat_cnt <= lat_cnt_nx;
            if (grant != IDLE) begin
                addr_q     <= mem_addr;
                resp_instr <= (grant == IRD);
                if (err_set) err <= 1'b1;
                if (grant == IRD && ibuf_hit) instr <= ibuf_data;
            end
            if (rd_done && state == DRD) data  <= mem_rdata;
            if (rd_done && state == IRD) instr <= mem_rdata;
        end
    end

    assign instr_valid = (state == RESP) && resp_instr;
    assign data_valid  = (state == RESP) && !resp_instr;
    assign instr_stall = rst && rd_instr_en && !instr_valid;
    assign data_stall  = rst && (rd_data_en || wr_data_en) && !data_valid;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed steps plus random
// transactions, checked against a transaction-level reference model
// (shadow memory, sticky error flag, optional one-entry fetch buffer).
module tb_cpu_mem_responder;

    localparam int unsigned LAT = 3;
    localparam int unsigned AW  = 14;
`ifdef CPU_MEM_RESPONDER_IBUF_EN
    localparam bit IBUF = 1'b1;
`else
    localparam bit IBUF = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [31:0]   instr_addr = '0, data_addr = '0, wrt_data = '0;
    logic          rd_instr_en = 1'b0, rd_data_en = 1'b0, wr_data_en = 1'b0;
    logic [31:0]   instr, data, mem_wdata, mem_rdata;
    logic          instr_valid, instr_stall, data_valid, data_stall, err;
    logic [AW-1:0] mem_addr;
    logic          mem_re, mem_we;

    int checks = 0;
    int errors = 0;

    cpu_mem_responder #(.ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .instr_addr(instr_addr), .rd_instr_en(rd_instr_en),
        .instr(instr), .instr_valid(instr_valid), .instr_stall(instr_stall),
        .data_addr(data_addr), .rd_data_en(rd_data_en), .wr_data_en(wr_data_en),
        .wrt_data(wrt_data), .data(data), .data_valid(data_valid),
        .data_stall(data_stall), .err(err),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned w);
        return 32'hA500_0000 ^ (w * 32'h9E37_79B1);
    endfunction

    // Backing RAM with LAT-cycle read pipeline
    logic [31:0] ram [int unsigned];
    logic [31:0] rpipe [LAT];

    function automatic logic [31:0] ram_rd(input int unsigned w);
        return ram.exists(w) ? ram[w] : init_word(w);
    endfunction

    always @(posedge clk) begin
        if (mem_we) ram[int'(mem_addr)] = mem_wdata;
        rpipe[0] <= mem_re ? ram_rd(int'(mem_addr)) : 32'hx;
        for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign mem_rdata = rpipe[LAT-1];

    // Reference model
    logic [31:0]   ref_mem [int unsigned];
    logic          m_err = 1'b0;
    logic [31:0]   m_data = '0, m_instr = '0;
    logic          ib_valid = 1'b0;
    int unsigned   ib_word = 0;

    function automatic logic [31:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_instr"},  instr, '0);
        check({tag, "_ivalid"}, 32'(instr_valid), 0);
        check({tag, "_istall"}, 32'(instr_stall), 0);
        check({tag, "_data"},   data, '0);
        check({tag, "_dvalid"}, 32'(data_valid), 0);
        check({tag, "_dstall"}, 32'(data_stall), 0);
        check({tag, "_err"},    32'(err), 0);
        check({tag, "_maddr"},  32'(mem_addr), 0);
        check({tag, "_mre"},    32'(mem_re), 0);
        check({tag, "_mwe"},    32'(mem_we), 0);
        check({tag, "_mwdata"}, mem_wdata, 0);
    endtask

    // kind: 0 fetch, 1 data read, 2 data write, 3 read+write together
    task automatic req(input int kind, input logic [31:0] a, input logic [31:0] wd);
        int unsigned w;
        logic        hit, is_i, v, st;
        int          exp_lat, k;
        logic [31:0] exp_val;
        w       = int'(a[15:2]);
        is_i    = (kind == 0);
        hit     = IBUF && is_i && ib_valid && (ib_word == w);
        exp_lat = (kind >= 2 || hit) ? 1 : int'(LAT) + 1;
        @(posedge clk); #1;
        if (is_i) begin rd_instr_en = 1'b1; instr_addr = a; end
        else begin
            data_addr  = a;
            wrt_data   = wd;
            rd_data_en = (kind == 1 || kind == 3);
            wr_data_en = (kind >= 2);
        end
        @(negedge clk);
        check("mem_re", 32'(mem_re), 32'(kind < 2 && !hit));
        check("mem_we", 32'(mem_we), 32'(kind >= 2));
        if (!hit) check("mem_addr", 32'(mem_addr), w);
        if (kind >= 2) check("mem_wdata", mem_wdata, wd);
        if (kind == 3 || a[1:0] != 2'b00) m_err = 1'b1;
        if (kind >= 2) begin
            ref_mem[w] = wd;
            if (ib_valid && ib_word == w) ib_valid = 1'b0;
            exp_val = m_data;
        end else begin
            exp_val = ref_rd(w);
        end
        if (is_i && IBUF) begin ib_valid = 1'b1; ib_word = w; end
        k = 0;
        v = is_i ? instr_valid : data_valid;
        while (!v && k < 16) begin
            st = is_i ? instr_stall : data_stall;
            check("stall_pending", 32'(st), 1);
            @(negedge clk);
            k++;
            v = is_i ? instr_valid : data_valid;
        end
        check(is_i ? "instr_latency" : "data_latency", k, exp_lat);
        check(is_i ? "instr_value" : "data_value", is_i ? instr : data, exp_val);
        check("stall_at_valid", 32'(is_i ? instr_stall : data_stall), 0);
        check("other_valid", 32'(is_i ? data_valid : instr_valid), 0);
        check("err_flag", 32'(err), 32'(m_err));
        if (is_i) m_instr = exp_val; else m_data = exp_val;
        rd_instr_en = 1'b0; rd_data_en = 1'b0; wr_data_en = 1'b0;
        @(negedge clk);
        check("valid_pulse_len", 32'(is_i ? instr_valid : data_valid), 0);
    endtask

    task automatic contend(input logic [31:0] ia, input logic [31:0] da);
        int unsigned iw, dw;
        logic        hit;
        int          dk, ik;
        logic [31:0] exp_d, exp_i;
        iw    = int'(ia[15:2]);
        dw    = int'(da[15:2]);
        hit   = IBUF && ib_valid && (ib_word == iw);
        dk    = int'(LAT) + 1;
        ik    = dk + 1 + (hit ? 1 : int'(LAT) + 1);
        exp_d = ref_rd(dw);
        exp_i = ref_rd(iw);
        @(posedge clk); #1;
        rd_instr_en = 1'b1; instr_addr = ia;
        rd_data_en  = 1'b1; data_addr  = da;
        if (IBUF) begin ib_valid = 1'b1; ib_word = iw; end
        for (int k = 0; k <= ik; k++) begin
            @(negedge clk);
            if (k == 0) check("ct_first_addr", 32'(mem_addr), dw);
            check("ct_dvalid", 32'(data_valid), 32'(k == dk));
            check("ct_ivalid", 32'(instr_valid), 32'(k == ik));
            check("ct_istall", 32'(instr_stall), 32'(k != ik));
            if (k == dk) begin
                check("ct_data", data, exp_d);
                m_data = exp_d;
                rd_data_en = 1'b0;
            end
            if (k == ik) begin
                check("ct_instr", instr, exp_i);
                m_instr = exp_i;
                rd_instr_en = 1'b0;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] up, a;
        int          kind;
        int unsigned w;

        ram[32'h40]     = 32'hDEAD_BEEF;
        ref_mem[32'h40] = 32'hDEAD_BEEF;

        // Reset state, with a request held to confirm outputs stay low
        rd_data_en = 1'b1;
        #23;
        check_zero("reset");
        rd_data_en = 1'b0;
        @(negedge clk); rst = 1'b1;

        // Instruction fetch from preloaded word
        req(0, 32'h0000_0100, '0);

        // Write then read back
        req(2, 32'h0000_0200, 32'h1234_5678);
        req(1, 32'h0000_0200, '0);

        // Same-cycle instruction and data reads
        contend(32'h0000_0400, 32'h0000_0204);

        // Refetch, write to the fetched word, refetch again
        req(0, 32'h0000_0100, '0);
        req(0, 32'h0000_0100, '0);
        req(2, 32'h0000_0100, 32'h0BAD_F00D);
        req(0, 32'h0000_0100, '0);

        // Random aligned traffic over a small window, upper bits scrambled
        for (int i = 0; i < 30; i++) begin
            kind = int'($urandom_range(0, 2));
            w    = $urandom_range(0, 15);
            up   = $urandom;
            a    = (up & 32'hFFFF_0000) | (w << 2);
            req(kind, a, $urandom);
        end
        check("err_clean", 32'(err), 0);

        // Protocol errors
        req(3, 32'h0000_0208, 32'hCAFE_F00D);
        req(1, 32'h0000_0203, '0);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(err), 1);

        // Reset in the middle of a data read
        @(posedge clk); #1;
        rd_data_en = 1'b1; data_addr = 32'h0000_0300;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check_zero("midreset");
        rd_data_en = 1'b0;
        m_err = 1'b0; m_data = '0; m_instr = '0; ib_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        for (int k = 0; k < 2 * int'(LAT) + 4; k++) begin
            @(negedge clk);
            check("post_reset_dvalid", 32'(data_valid), 0);
            check("post_reset_ivalid", 32'(instr_valid), 0);
        end
        req(0, 32'h0000_0100, '0);
        req(1, 32'h0000_0200, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
